// File: rtl/tree_eval_scheduler.sv
// -----------------------------------------------------------------------------
// tree_eval_scheduler
//   Shares a single weather decision-tree evaluator between NUM_REQ sensor
//   channels. A round-robin arbiter accepts one 16-bit feature sample at a
//   time. The scheduler starts the evaluator, waits for its answer under a
//   timeout guard, and returns the class tagged with the index of the
//   channel that owns it.
//
// Ports
//   CLOCK_50       in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   [NUM_REQ]     per-channel sample valid
//   req_data       in   [16*NUM_REQ]  per-channel {wind, precip, temp_min, temp_max}
//   req_ready      out  [NUM_REQ]     one-hot accept (combinational, IDLE only)
//   eval_start     out  one-cycle evaluator start pulse
//   eval_temp_max/eval_temp_min/eval_precip/eval_wind  out  latched features
//   eval_done      in   evaluator result strobe
//   eval_class     in   [3]  evaluator class
//   resp_valid     out  result available
//   resp_ready     in   consumer accepts the result
//   resp_class     out  [3]  class, 3'b111 = evaluator timeout
//   resp_idx       out  [IDX_W] owning requester
//   busy           out  high outside IDLE
// -----------------------------------------------------------------------------
module tree_eval_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 15,
   parameter int IDX_W   = 2
) (
   input  logic                   CLOCK_50,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [16*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   eval_start,
   output logic [3:0]             eval_temp_max,
   output logic [3:0]             eval_temp_min,
   output logic [3:0]             eval_precip,
   output logic [3:0]             eval_wind,
   input  logic                   eval_done,
   input  logic [2:0]             eval_class,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [2:0]             resp_class,
   output logic [IDX_W-1:0]       resp_idx,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_sel_idx;
   logic [7:0]           r_cnt;
   logic [15:0]          r_feat;
   logic                 r_eval_start;
   logic                 r_resp_valid;
   logic [2:0]           r_resp_class;
   logic [IDX_W-1:0]     r_resp_idx;
   logic                 r_busy;

   logic                 w_found;
   logic [IDX_W-1:0]     w_sel;
   logic [15:0]          w_sel_data;
   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_rr_nxt;
   logic [7:0]           w_cnt_nxt;

   // Round-robin pick in two passes: first the channels at or above rr_ptr,
   // then (wrap-around) everything from channel 0. The first hit wins.
   always_comb begin
      w_found    = 1'b0;
      w_sel      = '0;
      w_sel_data = '0;
      w_grant    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
            w_found    = 1'b1;
            w_sel      = IDX_W'(i);
            w_sel_data = req_data[16*i +: 16];
            w_grant    = '0;
            w_grant[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req_valid[i]) begin
            w_found    = 1'b1;
            w_sel      = IDX_W'(i);
            w_sel_data = req_data[16*i +: 16];
            w_grant    = '0;
            w_grant[i] = 1'b1;
         end
      end
   end

   // Pointer wraps at NUM_REQ, which need not be a power of two.
   assign w_rr_nxt  = (w_sel == IDX_W'(NUM_REQ-1)) ? '0 : w_sel + IDX_W'(1);
   assign w_cnt_nxt = r_cnt + 8'd1;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_sel_idx    <= '0;
         r_cnt        <= '0;
         r_feat       <= '0;
         r_eval_start <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_class <= '0;
         r_resp_idx   <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_feat       <= w_sel_data;
                  r_sel_idx    <= w_sel;
                  r_rr_ptr     <= w_rr_nxt;
                  r_eval_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_eval_start <= 1'b0;
               r_cnt        <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               // eval_done takes priority over a timeout in the same cycle
               if (eval_done) begin
                  r_resp_class <= eval_class;
                  r_resp_idx   <= r_sel_idx;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (w_cnt_nxt == 8'(TIMEOUT)) begin
                  r_resp_class <= 3'b111;
                  r_resp_idx   <= r_sel_idx;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = (r_state == S_IDLE) ? w_grant : '0;
   assign eval_start    = r_eval_start;
   assign eval_temp_max = r_feat[3:0];
   assign eval_temp_min = r_feat[7:4];
   assign eval_precip   = r_feat[11:8];
   assign eval_wind     = r_feat[15:12];
   assign resp_valid    = r_resp_valid;
   assign resp_class    = r_resp_class;
   assign resp_idx      = r_resp_idx;
   assign busy          = r_busy;

endmodule

// File: tb/tb_tree_eval_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tree_eval_scheduler
//   Directed bench for tree_eval_scheduler (NUM_REQ=4, TIMEOUT=15).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   1 unit later, well clear of the next edge. The evaluator is played by
//   the stimulus itself so every done pulse lands on a known cycle.
// -----------------------------------------------------------------------------
module tb_tree_eval_scheduler;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 15;
   localparam int IDX_W   = 2;

   logic                  CLOCK_50;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  eval_start;
   logic [3:0]            eval_temp_max, eval_temp_min, eval_precip, eval_wind;
   logic                  eval_done;
   logic [2:0]            eval_class;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [2:0]            resp_class;
   logic [IDX_W-1:0]      resp_idx;
   logic                  busy;

   int n_chk = 0;
   int n_err = 0;

   tree_eval_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)) dut (
      .CLOCK_50      (CLOCK_50),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .eval_start    (eval_start),
      .eval_temp_max (eval_temp_max),
      .eval_temp_min (eval_temp_min),
      .eval_precip   (eval_precip),
      .eval_wind     (eval_wind),
      .eval_done     (eval_done),
      .eval_class    (eval_class),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_class    (resp_class),
      .resp_idx      (resp_idx),
      .busy          (busy)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic logic [15:0] feats();
      return {eval_wind, eval_precip, eval_temp_min, eval_temp_max};
   endfunction

   task automatic set_ch(input int ch, input logic [15:0] d);
      req_data[16*ch +: 16] = d;
   endtask

   // Entered in an IDLE cycle with requests already driven. Checks the grant,
   // the start pulse and latched features, plays an evaluator answering
   // `lat` cycles after start, and returns in the following IDLE cycle.
   task automatic serve(input string tag, input int ch, input int lat,
                        input logic [2:0] cls, input logic [15:0] feat, input bit drop);
      #1;
      check({tag, "_grant"}, 32'(req_ready), 32'(1 << ch));
      tick();
      if (drop) req_valid[ch] = 1'b0;
      #1;
      check({tag, "_start"}, 32'(eval_start), 32'd1);
      check({tag, "_feat"},  32'(feats()), 32'(feat));
      check({tag, "_busy"},  32'(busy), 32'd1);
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k == lat) begin
            eval_done  = 1'b1;
            eval_class = cls;
         end
         #1;
         check({tag, "_nostart"}, 32'(eval_start), 32'd0);
         check({tag, "_noready"}, 32'(req_ready), 32'd0);
         check({tag, "_noresp"},  32'(resp_valid), 32'd0);
      end
      tick();
      eval_done = 1'b0;
      #1;
      check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
      check({tag, "_rclass"}, 32'(resp_class), 32'(cls));
      check({tag, "_ridx"},   32'(resp_idx), 32'(ch));
      check({tag, "_rready"}, 32'(req_ready), 32'd0);
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      eval_done  = 1'b0;
      eval_class = 3'b000;
      resp_ready = 1'b1;

      // ---- reset state ----
      #2;
      check("rst_ready",  32'(req_ready), 32'd0);
      check("rst_start",  32'(eval_start), 32'd0);
      check("rst_feat",   32'(feats()), 32'd0);
      check("rst_rvalid", 32'(resp_valid), 32'd0);
      check("rst_rclass", 32'(resp_class), 32'd0);
      check("rst_ridx",   32'(resp_idx), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // ---- single request, channel 2, evaluator answers 3 cycles after start ----
      set_ch(2, 16'h935C);
      req_valid = 4'b0100;
      serve("single", 2, 3, 3'b001, 16'h935C, 1'b1);
      #1;
      check("single_idle_busy",   32'(busy), 32'd0);
      check("single_idle_rvalid", 32'(resp_valid), 32'd0);
      tick();

      // ---- round robin from a fresh pointer, all channels held valid ----
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ch(i, 16'h1111 * 16'(i + 1));
      req_valid = 4'b1111;
      serve("rr0", 0, 2, 3'b000, 16'h1111, 1'b0);
      serve("rr1", 1, 2, 3'b001, 16'h2222, 1'b0);
      serve("rr2", 2, 2, 3'b110, 16'h3333, 1'b0);
      serve("rr3", 3, 2, 3'b001, 16'h4444, 1'b0);
      serve("rr4", 0, 2, 3'b110, 16'h1111, 1'b0);
      req_valid = '0;
      tick();

      // ---- timeout: rr_ptr is 1, only channel 3 requests, no answer ----
      set_ch(3, 16'hABCD);
      req_valid = 4'b1000;
      #1;
      check("to_grant", 32'(req_ready), 32'b1000);
      tick();
      req_valid = '0;
      #1;
      check("to_start", 32'(eval_start), 32'd1);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         #1;
         check("to_wait_noresp", 32'(resp_valid), 32'd0);
      end
      tick();
      #1;
      check("to_rvalid", 32'(resp_valid), 32'd1);
      check("to_rclass", 32'(resp_class), 32'b111);
      check("to_ridx",   32'(resp_idx), 32'd3);
      tick();
      // stray done while idle must not start anything
      eval_done  = 1'b1;
      eval_class = 3'b001;
      tick();
      eval_done = 1'b0;
      #1;
      check("stray_busy",   32'(busy), 32'd0);
      check("stray_rvalid", 32'(resp_valid), 32'd0);
      check("stray_rclass", 32'(resp_class), 32'b111);
      tick();
      set_ch(0, 16'h0F1E);
      req_valid = 4'b0001;
      serve("after_to", 0, 1, 3'b110, 16'h0F1E, 1'b1);

      // ---- done on the very cycle the counter hits TIMEOUT ----
      set_ch(1, 16'h5A5A);
      req_valid = 4'b0010;
      serve("simul", 1, TIMEOUT, 3'b110, 16'h5A5A, 1'b1);

      // ---- backpressure: channel 1 keeps requesting while resp is stalled ----
      set_ch(2, 16'h7654);
      req_valid  = 4'b0100;
      #1;
      check("bp_grant", 32'(req_ready), 32'b0100);
      tick();
      req_valid  = 4'b0010;
      resp_ready = 1'b0;
      #1;
      check("bp_start", 32'(eval_start), 32'd1);
      tick();
      eval_done  = 1'b1;
      eval_class = 3'b001;
      tick();
      eval_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("bp_rvalid", 32'(resp_valid), 32'd1);
         check("bp_rclass", 32'(resp_class), 32'b001);
         check("bp_ridx",   32'(resp_idx), 32'd2);
         check("bp_noready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_release_rvalid", 32'(resp_valid), 32'd1);
      tick();
      #1;
      check("bp_next_grant", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      #1;
      check("bp_next_start", 32'(eval_start), 32'd1);
      check("bp_next_feat",  32'(feats()), 32'h5A5A);
      tick();
      eval_done  = 1'b1;
      eval_class = 3'b110;
      tick();
      eval_done = 1'b0;
      #1;
      check("bp_next_rclass", 32'(resp_class), 32'b110);
      check("bp_next_ridx",   32'(resp_idx), 32'd1);
      tick();

      // ---- async reset in the middle of WAIT (rr_ptr becomes 2 first) ----
      set_ch(1, 16'hC3C3);
      req_valid = 4'b0010;
      #1;
      check("ar_grant", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_busy",   32'(busy), 32'd0);
      check("ar_start",  32'(eval_start), 32'd0);
      check("ar_feat",   32'(feats()), 32'd0);
      check("ar_rvalid", 32'(resp_valid), 32'd0);
      check("ar_rclass", 32'(resp_class), 32'd0);
      check("ar_ridx",   32'(resp_idx), 32'd0);
      tick();
      rst_n = 1'b1;
      // late answer from the abandoned evaluation
      eval_done  = 1'b1;
      eval_class = 3'b001;
      tick();
      eval_done = 1'b0;
      #1;
      check("ar_late_busy",   32'(busy), 32'd0);
      check("ar_late_rvalid", 32'(resp_valid), 32'd0);
      tick();
      set_ch(0, 16'h2468);
      set_ch(2, 16'h1357);
      req_valid = 4'b0101;
      serve("ar_after", 0, 2, 3'b001, 16'h2468, 1'b1);
      req_valid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
